// File: rtl/if_id_imm_stage.sv
// IF/ID pipeline stage with one-entry skid buffer and registered 64-bit immediate decode.
// Optional feature macro: IF_ID_BYTE_OFFSET_EN (branch immediates become byte offsets).
module if_id_imm_stage #(
   parameter int          PC_WIDTH  = 64,
   parameter logic [31:0] NOP_INSTR = 32'h8B1F03FF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr_in,
   input  logic [PC_WIDTH-1:0] pc_in,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         instr_out,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [2:0]          imm_kind,
   output logic [63:0]         imm_out
);

   localparam logic [2:0] KIND_NONE   = 3'd0;
   localparam logic [2:0] KIND_ALU12  = 3'd1;
   localparam logic [2:0] KIND_DADDR9 = 3'd2;
   localparam logic [2:0] KIND_BR26   = 3'd3;
   localparam logic [2:0] KIND_CBR19  = 3'd4;
   localparam logic [2:0] KIND_SHAMT6 = 3'd5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0]  kind;
      logic [63:0] imm;
   } imm_t;

   // First matching rule wins; signed fields sign-extend, unsigned fields zero-extend.
   function automatic imm_t decode_imm(input logic [31:0] ins);
      imm_t r;
      r.kind = KIND_NONE;
      r.imm  = 64'd0;
      if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
         r.kind = KIND_BR26;
`ifdef IF_ID_BYTE_OFFSET_EN
         r.imm  = {{36{ins[25]}}, ins[25:0], 2'b00};
`else
         r.imm  = {{38{ins[25]}}, ins[25:0]};
`endif
      end else if (ins[31:24] == 8'b10110100 || ins[31:24] == 8'b10110101 ||
                   ins[31:24] == 8'b01010100) begin
         r.kind = KIND_CBR19;
`ifdef IF_ID_BYTE_OFFSET_EN
         r.imm  = {{43{ins[23]}}, ins[23:5], 2'b00};
`else
         r.imm  = {{45{ins[23]}}, ins[23:5]};
`endif
      end else if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
         r.kind = KIND_DADDR9;
         r.imm  = {{55{ins[20]}}, ins[20:12]};
      end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1101000100) begin
         r.kind = KIND_ALU12;
         r.imm  = {52'd0, ins[21:10]};
      end else if (ins[31:21] == 11'b11010011011 || ins[31:21] == 11'b11010011010) begin
         r.kind = KIND_SHAMT6;
         r.imm  = {58'd0, ins[15:10]};
      end else begin
         r.kind = KIND_NONE;
         r.imm  = 64'd0;
      end
      return r;
   endfunction

   state_t              state;
   state_t              state_next;
   imm_t                dec;
   logic                load_or_in;
   logic                load_or_sk;
   logic                load_sk;
   logic                clear_or;

   logic [31:0]         sk_instr;
   logic [PC_WIDTH-1:0] sk_pc;
   logic [2:0]          sk_kind;
   logic [63:0]         sk_imm;

   assign dec = decode_imm(instr_in);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush overrides every transfer.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_valid) state_next = ONE;
               else          state_next = EMPTY;
            end
            ONE: begin
               if (in_valid && !out_ready)      state_next = FULL;
               else if (!in_valid && out_ready) state_next = EMPTY;
               else                             state_next = ONE;
            end
            FULL: begin
               if (out_ready) state_next = ONE;
               else           state_next = FULL;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Handshake outputs and datapath load enables.
   always_comb begin
      in_ready   = (state != FULL);
      out_valid  = (state == ONE) || (state == FULL);
      load_or_in = 1'b0;
      load_or_sk = 1'b0;
      load_sk    = 1'b0;
      clear_or   = 1'b0;
      if (flush) begin
         clear_or = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               load_or_in = in_valid;
            end
            ONE: begin
               if (in_valid && out_ready) load_or_in = 1'b1;
               else if (in_valid)         load_sk    = 1'b1;
               else if (out_ready)        clear_or   = 1'b1;
               else                       clear_or   = 1'b0;
            end
            FULL: begin
               load_or_sk = out_ready;
            end
            default: begin
               clear_or = 1'b1;
            end
         endcase
      end
   end

   // Output register; an invalid entry shows NOP with a zero immediate, PC is held.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_out <= NOP_INSTR;
         pc_out    <= '0;
         imm_kind  <= KIND_NONE;
         imm_out   <= 64'd0;
      end else if (load_or_in) begin
         instr_out <= instr_in;
         pc_out    <= pc_in;
         imm_kind  <= dec.kind;
         imm_out   <= dec.imm;
      end else if (load_or_sk) begin
         instr_out <= sk_instr;
         pc_out    <= sk_pc;
         imm_kind  <= sk_kind;
         imm_out   <= sk_imm;
      end else if (clear_or) begin
         instr_out <= NOP_INSTR;
         imm_kind  <= KIND_NONE;
         imm_out   <= 64'd0;
      end
   end

   // Skid register; its occupancy is tracked by the FULL state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sk_instr <= 32'd0;
         sk_pc    <= '0;
         sk_kind  <= KIND_NONE;
         sk_imm   <= 64'd0;
      end else if (load_sk) begin
         sk_instr <= instr_in;
         sk_pc    <= pc_in;
         sk_kind  <= dec.kind;
         sk_imm   <= dec.imm;
      end
   end

endmodule

// File: tb/tb_if_id_imm_stage.sv
// Randomized and directed bench for if_id_imm_stage against a two-deep FIFO reference model.
module tb_if_id_imm_stage;

   localparam logic [31:0] NOP = 32'h8B1F03FF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_in;
   logic [63:0] pc_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic [63:0] pc_out;
   logic [2:0]  imm_kind;
   logic [63:0] imm_out;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic [2:0]  kind;
      logic [63:0] imm;
   } ent_t;

   ent_t        q[$];
   logic [63:0] last_pc;
   logic [31:0] obs[$];

   if_id_imm_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr_in(instr_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out),
      .imm_kind(imm_kind), .imm_out(imm_out)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] fld(input logic [31:0] ins, input int lo, input int w);
      longint unsigned u;
      u = 64'(ins);
      return (u >> lo) & ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      logic [63:0] m;
      m = 64'd1 << (w - 1);
      return (v ^ m) - m;
   endfunction

   // Reference decode written from the opcode table as integer comparisons.
   function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] k, output logic [63:0] imm);
      logic [63:0] op6, op8, op10, op11;
      op6 = fld(ins, 26, 6); op8 = fld(ins, 24, 8); op10 = fld(ins, 22, 10); op11 = fld(ins, 21, 11);
      k = 3'd0; imm = 64'd0;
      if (op6 == 64'd5 || op6 == 64'd37) begin
         k = 3'd3; imm = sext(fld(ins, 0, 26), 26);
`ifdef IF_ID_BYTE_OFFSET_EN
         imm = imm * 64'd4;
`endif
      end else if (op8 == 64'hB4 || op8 == 64'hB5 || op8 == 64'h54) begin
         k = 3'd4; imm = sext(fld(ins, 5, 19), 19);
`ifdef IF_ID_BYTE_OFFSET_EN
         imm = imm * 64'd4;
`endif
      end else if (op11 == 64'h7C2 || op11 == 64'h7C0) begin
         k = 3'd2; imm = sext(fld(ins, 12, 9), 9);
      end else if (op10 == 64'h244 || op10 == 64'h344) begin
         k = 3'd1; imm = fld(ins, 10, 12);
      end else if (op11 == 64'h69B || op11 == 64'h69A) begin
         k = 3'd5; imm = fld(ins, 10, 6);
      end
   endfunction

   // Apply one cycle of inputs, advance the model, record DUT output transfers.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic fl, input logic ordy, output logic acc);
      logic pop, push;
      ent_t e;
      in_valid = v; instr_in = ins; pc_in = pc; flush = fl; out_ready = ordy;
      acc = 1'b0;
      if (out_valid && ordy && !fl) obs.push_back(instr_out);
      if (fl) begin
         q.delete();
      end else begin
         pop  = (q.size() > 0) && ordy;
         push = v && (q.size() < 2);
         if (pop) void'(q.pop_front());
         if (push) begin
            e.instr = ins; e.pc = pc;
            ref_dec(ins, e.kind, e.imm);
            q.push_back(e);
            acc = 1'b1;
         end
      end
      if (q.size() > 0) last_pc = q[0].pc;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; instr_in = 32'd0; pc_in = 64'd0;
      flush = 1'b0; out_ready = 1'b0;
      q.delete(); last_pc = 64'd0;
      #13;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== NOP || pc_out !== 64'd0 ||
          imm_kind !== 3'd0 || imm_out !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b ready=%b instr=%h pc=%h kind=%0d imm=%h, want 0 1 %h 0 0 0",
                  out_valid, in_ready, instr_out, pc_out, imm_kind, imm_out, NOP);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_decode();
      logic acc;
      logic [63:0] exp_b, exp_c;
`ifdef IF_ID_BYTE_OFFSET_EN
      exp_b = 64'hFFFFFFFFFFFFFFFC; exp_c = 64'hC;
`else
      exp_b = 64'hFFFFFFFFFFFFFFFF; exp_c = 64'h3;
`endif
      drive(1'b1, 32'h91001441, 64'h40, 1'b0, 1'b1, acc);
      n_checks++;
      if (out_valid !== 1'b1 || imm_kind !== 3'd1 || imm_out !== 64'h5 || pc_out !== 64'h40) begin
         n_fail++;
         $display("FAIL addi: valid=%b kind=%0d imm=%h pc=%h, want 1 1 5 40", out_valid, imm_kind, imm_out, pc_out);
      end
      drive(1'b1, 32'hF85F8083, 64'h44, 1'b0, 1'b1, acc);
      n_checks++;
      if (imm_kind !== 3'd2 || imm_out !== 64'hFFFFFFFFFFFFFFF8) begin
         n_fail++;
         $display("FAIL ldur: kind=%0d imm=%h, want 2 fffffffffffffff8", imm_kind, imm_out);
      end
      drive(1'b1, 32'h17FFFFFF, 64'h48, 1'b0, 1'b1, acc);
      n_checks++;
      if (imm_kind !== 3'd3 || imm_out !== exp_b) begin
         n_fail++;
         $display("FAIL b: kind=%0d imm=%h, want 3 %h", imm_kind, imm_out, exp_b);
      end
      drive(1'b1, 32'hB4000060, 64'h4C, 1'b0, 1'b1, acc);
      n_checks++;
      if (imm_kind !== 3'd4 || imm_out !== exp_c) begin
         n_fail++;
         $display("FAIL cbz: kind=%0d imm=%h, want 4 %h", imm_kind, imm_out, exp_c);
      end
      drive(1'b1, {11'b11010011011, 5'd0, 6'd13, 10'd0}, 64'h50, 1'b0, 1'b1, acc);
      n_checks++;
      if (imm_kind !== 3'd5 || imm_out !== 64'd13) begin
         n_fail++;
         $display("FAIL shamt: kind=%0d imm=%h, want 5 d", imm_kind, imm_out);
      end
      drive(1'b1, NOP, 64'h54, 1'b0, 1'b1, acc);
      n_checks++;
      if (out_valid !== 1'b1 || imm_kind !== 3'd0 || imm_out !== 64'd0 || instr_out !== NOP) begin
         n_fail++;
         $display("FAIL none: valid=%b kind=%0d imm=%h, want 1 0 0", out_valid, imm_kind, imm_out);
      end
      drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, acc);
      n_checks++;
      if (out_valid !== 1'b0 || instr_out !== NOP || pc_out !== 64'h54) begin
         n_fail++;
         $display("FAIL drain: valid=%b instr=%h pc=%h, want 0 %h 54", out_valid, instr_out, pc_out, NOP);
      end
   endtask

   task automatic test_stall();
      logic acc, c_sent;
      obs.delete();
      drive(1'b1, 32'hA0A0A0A0, 64'h100, 1'b0, 1'b0, acc);
      drive(1'b1, 32'hB0B0B0B0, 64'h104, 1'b0, 1'b0, acc);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || instr_out !== 32'hA0A0A0A0) begin
         n_fail++;
         $display("FAIL stall_full: ready=%b valid=%b instr=%h, want 0 1 a0a0a0a0", in_ready, out_valid, instr_out);
      end
      drive(1'b1, 32'hC0C0C0C0, 64'h108, 1'b0, 1'b0, acc);
      n_checks++;
      if (in_ready !== 1'b0 || instr_out !== 32'hA0A0A0A0 || pc_out !== 64'h100) begin
         n_fail++;
         $display("FAIL stall_hold: ready=%b instr=%h pc=%h, want 0 a0a0a0a0 100", in_ready, instr_out, pc_out);
      end
      c_sent = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!c_sent) drive(1'b1, 32'hC0C0C0C0, 64'h108, 1'b0, 1'b1, c_sent);
         else         drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, acc);
      end
      n_checks++;
      if (obs.size() != 3 || obs[0] !== 32'hA0A0A0A0 || obs[1] !== 32'hB0B0B0B0 || obs[2] !== 32'hC0C0C0C0) begin
         n_fail++;
         $display("FAIL stall_order: got %0d entries first=%h, want 3 entries a0a0a0a0 b0b0b0b0 c0c0c0c0",
                  obs.size(), (obs.size() > 0) ? obs[0] : 32'd0);
      end
   endtask

   task automatic test_flush();
      logic acc;
      drive(1'b1, 32'hD0D0D0D0, 64'h200, 1'b0, 1'b0, acc);
      drive(1'b1, 32'hE0E0E0E0, 64'h204, 1'b0, 1'b0, acc);
      drive(1'b1, 32'hF0F0F0F0, 64'h208, 1'b1, 1'b1, acc);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== NOP || imm_out !== 64'd0 ||
          imm_kind !== 3'd0 || pc_out !== 64'h200) begin
         n_fail++;
         $display("FAIL flush: valid=%b ready=%b instr=%h imm=%h kind=%0d pc=%h, want 0 1 %h 0 0 200",
                  out_valid, in_ready, instr_out, imm_out, imm_kind, pc_out, NOP);
      end
      drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, acc);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_after: valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_async_reset();
      logic acc;
      drive(1'b1, 32'h91001441, 64'h300, 1'b0, 1'b0, acc);
      drive(1'b1, 32'hF85F8083, 64'h304, 1'b0, 1'b0, acc);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== NOP || pc_out !== 64'd0 ||
          imm_kind !== 3'd0 || imm_out !== 64'd0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b ready=%b instr=%h pc=%h kind=%0d imm=%h, want 0 1 %h 0 0 0",
                  out_valid, in_ready, instr_out, pc_out, imm_kind, imm_out, NOP);
      end
      q.delete(); last_pc = 64'd0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic acc, v, fl, ordy;
      logic [31:0] ins;
      logic [63:0] pc;
      logic [31:0] e_instr;
      logic [2:0]  e_kind;
      logic [63:0] e_imm;
      logic [5:0]  ops6 [2]  = '{6'b000101, 6'b100101};
      logic [7:0]  ops8 [3]  = '{8'hB4, 8'hB5, 8'h54};
      logic [10:0] ops11[4]  = '{11'h7C2, 11'h7C0, 11'h69B, 11'h69A};
      logic [9:0]  ops10[2]  = '{10'h244, 10'h344};
      pc = 64'h1000;
      for (int i = 0; i < 600; i++) begin
         e_instr = (q.size() > 0) ? q[0].instr : NOP;
         e_kind  = (q.size() > 0) ? q[0].kind  : 3'd0;
         e_imm   = (q.size() > 0) ? q[0].imm   : 64'd0;
         n_checks++;
         if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || instr_out !== e_instr ||
             imm_kind !== e_kind || imm_out !== e_imm || pc_out !== last_pc) begin
            n_fail++;
            $display("FAIL random cyc %0d: valid=%b ready=%b instr=%h kind=%0d imm=%h pc=%h, want %b %b %h %0d %h %h",
                     i, out_valid, in_ready, instr_out, imm_kind, imm_out, pc_out,
                     q.size() > 0, q.size() < 2, e_instr, e_kind, e_imm, last_pc);
         end
         ins = $urandom;
         case ($urandom_range(0, 4))
            0: ins[31:26] = ops6[$urandom_range(0, 1)];
            1: ins[31:24] = ops8[$urandom_range(0, 2)];
            2: ins[31:21] = ops11[$urandom_range(0, 3)];
            3: ins[31:22] = ops10[$urandom_range(0, 1)];
            default: ;
         endcase
         v    = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 15) == 0);
         pc   = pc + 64'd4;
         drive(v, ins, pc, fl, ordy, acc);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_id_imm_stage.md
Name: if_id_imm_stage

Overview:
- IF/ID pipeline stage that sits directly upstream of the 64-bit sign extender in the pipelined LEGv8 processor.
- Registers the fetched instruction and PC, classifies the immediate format, and presents a 64-bit immediate. Signed fields are sign-extended; unsigned fields are zero-extended.
- Uses valid/ready handshakes on both sides, with a one-entry skid buffer so stalls do not drop fetched instructions.
- Supports a synchronous flush for taken branches.

Parameters:
PC_WIDTH, 64, width of pc_in/pc_out
NOP_INSTR, 32'h8B1F03FF, encoding substituted on the output bus whenever out_valid=0

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept; transfer occurs when in_valid&in_ready
instr_in  input  32  fetched instruction
pc_in  input  PC_WIDTH  PC of instr_in
flush  input  1  discard all held and incoming instructions this cycle
out_valid  output  1  decode-side entry is valid
out_ready  input  1  decode accepts; transfer occurs when out_valid&out_ready
instr_out  output  32  registered instruction (NOP_INSTR when !out_valid)
pc_out  output  PC_WIDTH  registered PC
imm_kind  output  3  0 NONE, 1 ALU12, 2 DADDR9, 3 BR26, 4 CBR19, 5 SHAMT6
imm_out  output  64  extended immediate for the output entry

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and reset_n.
- Reset values, applied immediately on reset_n=0:
  - out_valid=0, skid empty, in_ready=1.
  - instr_out=NOP_INSTR, pc_out=0, imm_kind=0, imm_out=0.
- Storage: output register (OR) plus skid register (SK). States:
  - EMPTY: OR invalid.
  - ONE: OR valid, SK empty.
  - FULL: both valid.
- Outputs: in_ready = !SK.valid. All outputs come from OR. Latency from input transfer to out_valid is 1 cycle.
- EMPTY: an input transfer loads OR and moves to ONE.
- ONE:
  - input transfer with out_ready=1: OR reloads and stays in ONE.
  - input transfer with out_ready=0: the entry goes to SK and moves to FULL.
  - no input transfer with out_ready=1: moves to EMPTY.
- FULL (in_ready=0):
  - out_ready=1: SK moves to OR and the state moves to ONE.
  - out_ready=0: hold.
- No entry is ever dropped or duplicated. Order is strictly FIFO.
- flush=1 has priority over everything:
  - next cycle is EMPTY.
  - the input is not captured, even if in_valid=1 (in_ready still reads 1 when SK is empty; fetch discards).
  - the output transfer that cycle is also void.
- Immediate decode is computed on entry capture and stored with the entry, so imm_out is registered and imm_kind/imm_out always match instr_out. Matching rules:
  - [31:26]=000101 or 100101 (B/BL): BR26 = sign-extend [25:0].
  - [31:24]=10110100, 10110101 or 01010100 (CBZ/CBNZ/B.cond): CBR19 = sign-extend [23:5].
  - [31:21]=11111000010 or 11111000000 (LDUR/STUR): DADDR9 = sign-extend [20:12].
  - [31:22]=1001000100 or 1101000100 (ADDI/SUBI): ALU12 = zero-extend [21:10].
  - [31:21]=11010011011 or 11010011010 (LSL/LSR): SHAMT6 = zero-extend [15:10].
  - otherwise NONE, imm_out=0.
- Decode priority follows the order listed above.
- When out_valid=0: instr_out=NOP_INSTR, imm_kind=0, imm_out=0. pc_out holds its last value.
- Reset asserted mid-operation discards both entries immediately.

Optional Feature:
- Macro: IF_ID_BYTE_OFFSET_EN.
- Defined: BR26 and CBR19 immediates are shifted left by 2 after sign extension (byte offsets); bits above 63 are discarded.
- Undefined: branch immediates are word offsets, unshifted.
- DADDR9, ALU12 and SHAMT6 are unaffected in both builds.

Test Plan:
- Reset then instr_in=0x91001441 (ADDI X1,X2,#5), pc_in=0x40, out_ready=1 -> next cycle out_valid=1, imm_kind=1, imm_out=0x5, pc_out=0x40.
- instr_in=0xF85F8083 (LDUR X3,[X4,#-8]) -> imm_kind=2, imm_out=0xFFFFFFFFFFFFFFF8.
- instr_in=0x17FFFFFF (B #-1) -> imm_kind=3, imm_out=0xFFFFFFFFFFFFFFFF, or 0xFFFFFFFFFFFFFFFC with IF_ID_BYTE_OFFSET_EN; instr_in=0xB4000060 (CBZ X0,#3) -> imm_kind=4, imm_out=0x3 (0xC with macro).
- Stall: send A,B,C back-to-back with out_ready=0 from cycle 1 -> in_ready=0 after B; release -> A, B, C emerge in order with no loss or duplication.
- flush=1 while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, instr_out=NOP_INSTR, imm_out=0.
- Drop reset_n asynchronously while FULL -> outputs reach reset values before the next clk edge.
